// File: rtl/maskmul_pkg.sv
// Shared constants and GF(2^2) arithmetic for the masked multiplier block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Element encoding: 0, 1, 2 = x, 3 = x+1, reduced modulo x^2 + x + 1.
// Pin-index constants give the LSB of each field on the TT user pins.
package maskmul_pkg;

  localparam int GF_W = 2;

  // ui_in field LSBs
  localparam int UI_AM_LSB = 0;
  localparam int UI_BM_LSB = 2;
  localparam int UI_MA_LSB = 4;
  localparam int UI_MB_LSB = 6;

  // uio_in field positions
  localparam int UIO_MQ_LSB = 0;
  localparam int UIO_HEAD   = 2;
  localparam int UIO_PCLK   = 3;
  localparam int UIO_SET    = 4;

  // uo_out field positions
  localparam int UO_QM_LSB  = 0;
  localparam int UO_TAIL    = 2;

  // GF(2^2) multiply. The high-by-high term c folds back into both bits
  // because x^2 reduces to x + 1.
  function automatic logic [GF_W-1:0] gf4_mul(input logic [GF_W-1:0] p,
                                               input logic [GF_W-1:0] r);
    logic c;
    c = p[1] & r[1];
    gf4_mul = {(p[1] & r[0]) ^ (p[0] & r[1]) ^ c, (p[0] & r[0]) ^ c};
  endfunction

endpackage

// File: rtl/gf4_mul_masked.sv
// Masked GF(2^2) multiply: qm = (a*b) ^ mq from shares, plain operands never formed.
// Latency: 1 clk (registered output).
// Backpressure: none; accepts a new operand set every cycle.
//
// Ports: clk, reset (sync, active-high); am/ma and bm/mb are the two shares of
// a and b; mq is the fresh output mask; qm is the registered masked product.
module gf4_mul_masked
  import maskmul_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [GF_W-1:0] am,
  input  logic [GF_W-1:0] bm,
  input  logic [GF_W-1:0] ma,
  input  logic [GF_W-1:0] mb,
  input  logic [GF_W-1:0] mq,
  output logic [GF_W-1:0] qm
);

  logic [GF_W-1:0] ambm;
  logic [GF_W-1:0] ammb;
  logic [GF_W-1:0] bmma;
  logic [GF_W-1:0] mamb;
  logic [GF_W-1:0] qm_r;

  assign ambm = gf4_mul(am, bm);
  assign ammb = gf4_mul(am, mb);
  assign bmma = gf4_mul(bm, ma);
  assign mamb = gf4_mul(ma, mb);

  // The output mask is applied before any other cross-product is folded in,
  // so no intermediate XOR ever holds an unmasked value.
  always_ff @(posedge clk) begin
    if (reset) begin
      qm_r <= '0;
    end else begin
      qm_r <= (((ambm ^ mq) ^ ammb) ^ bmma) ^ mamb;
    end
  end

  assign qm = qm_r;

endmodule

// File: rtl/tt_openfpga_top.sv
// TinyTapeout wrapper: masked GF(2^2) multiplier plus optional ccff config chain.
// Latency: 1 clk for qm; config chain shifts ~2 clk after each prog_clk rise.
// Backpressure: none; free-running, no handshake.
//
// Ports: clk, reset (sync, active-high), ena (ignored);
//   ui_in  [1:0]=am [3:2]=bm [5:4]=ma [7:6]=mb
//   uio_in [1:0]=mq [2]=ccff_head [3]=prog_clk [4]=set
//   uo_out [1:0]=qm [2]=ccff_tail, rest 0; uio_out/uio_oe all 0.
// Build option MASKMUL_CFG_CHAIN_EN: when defined, the prog_clk/head/set
// synchronizers and CFG_LEN-bit chain are built; otherwise ccff_tail is 0.
module tt_openfpga_top #(
  parameter int CFG_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import maskmul_pkg::*;

  logic [GF_W-1:0] qm;
  logic            ccff_tail;

  gf4_mul_masked u_mul (
    .clk   (clk),
    .reset (reset),
    .am    (ui_in[UI_AM_LSB +: GF_W]),
    .bm    (ui_in[UI_BM_LSB +: GF_W]),
    .ma    (ui_in[UI_MA_LSB +: GF_W]),
    .mb    (ui_in[UI_MB_LSB +: GF_W]),
    .mq    (uio_in[UIO_MQ_LSB +: GF_W]),
    .qm    (qm)
  );

`ifdef MASKMUL_CFG_CHAIN_EN
  logic               ps0, ps1;
  logic               hs0, hs1;
  logic               ss0, ss1;
  logic               shift_pulse;
  logic [CFG_LEN-1:0] cfg;

  // head goes through the same two stages as prog_clk so the bit sampled on a
  // shift is the one that was stable around the prog_clk rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps0 <= 1'b0;
      ps1 <= 1'b0;
      hs0 <= 1'b0;
      hs1 <= 1'b0;
      ss0 <= 1'b0;
      ss1 <= 1'b0;
    end else begin
      ps0 <= uio_in[UIO_PCLK];
      ps1 <= ps0;
      hs0 <= uio_in[UIO_HEAD];
      hs1 <= hs0;
      ss0 <= uio_in[UIO_SET];
      ss1 <= ss0;
    end
  end

  assign shift_pulse = ps0 & ~ps1;

  if (CFG_LEN == 1) begin : g_chain_one
    always_ff @(posedge clk) begin
      if (reset) begin
        cfg <= '0;
      end else if (ss1) begin
        cfg <= '1;
      end else if (shift_pulse) begin
        cfg <= hs1;
      end
    end
  end else begin : g_chain_n
    always_ff @(posedge clk) begin
      if (reset) begin
        cfg <= '0;
      end else if (ss1) begin
        cfg <= '1;
      end else if (shift_pulse) begin
        cfg <= {cfg[CFG_LEN-2:0], hs1};
      end
    end
  end

  assign ccff_tail = cfg[CFG_LEN-1];

  logic unused_sink;
  assign unused_sink = &{1'b0, ena, uio_in[7:5]};
`else
  assign ccff_tail = 1'b0;

  logic unused_sink;
  assign unused_sink = &{1'b0, ena, uio_in[7:2], CFG_LEN[0]};
`endif

  always_comb begin
    uo_out                       = '0;
    uo_out[UO_QM_LSB +: GF_W]    = qm;
    uo_out[UO_TAIL]              = ccff_tail;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_openfpga_top.sv
// Directed and random checks of the masked GF(2^2) multiplier top.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_tt_openfpga_top;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [1:0] exp_qm;
  int hist_a [4];
  int hist_b [4];

`ifdef MASKMUL_CFG_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  tt_openfpga_top #(.CFG_LEN(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Hand-written GF(4) product table, x^2 = x + 1.
  function automatic logic [1:0] ref_mul(input logic [1:0] p, input logic [1:0] r);
    logic [1:0] v;
    v = 2'd0;
    case (p)
      2'd0: v = 2'd0;
      2'd1: v = r;
      2'd2: case (r) 2'd0: v = 2'd0; 2'd1: v = 2'd2; 2'd2: v = 2'd3; default: v = 2'd1; endcase
      default: case (r) 2'd0: v = 2'd0; 2'd1: v = 2'd3; 2'd2: v = 2'd1; default: v = 2'd2; endcase
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [1:0] am, input logic [1:0] bm,
                         input logic [1:0] ma, input logic [1:0] mb,
                         input logic [1:0] mq);
    ui_in       = {mb, ma, bm, am};
    uio_in[1:0] = mq;
  endtask

  // Random operands for one cycle, then check the product after the edge.
  task automatic tick_rand(input string tag);
    logic [1:0] am, bm, ma, mb, mq;
    am = 2'($urandom_range(3)); bm = 2'($urandom_range(3));
    ma = 2'($urandom_range(3)); mb = 2'($urandom_range(3));
    mq = 2'($urandom_range(3));
    set_ops(am, bm, ma, mb, mq);
    exp_qm = ref_mul(am ^ ma, bm ^ mb) ^ mq;
    hist_a[am ^ ma]++;
    hist_b[bm ^ mb]++;
    step();
    chk(tag, {6'd0, uo_out[1:0]}, {6'd0, exp_qm});
  endtask

  task automatic cfg_pulse(input logic head);
    uio_in[2] = head;
    uio_in[3] = 1'b0;
    for (int i = 0; i < 4; i++) tick_rand("chain_qm");
    uio_in[3] = 1'b1;
    for (int i = 0; i < 4; i++) tick_rand("chain_qm");
    uio_in[3] = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    set_ops(2'd3, 2'd3, 2'd1, 2'd2, 2'd1);
    step();
    step();
    chk("reset_uo_out", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);
    reset = 1'b0;

    // Unmasked products
    set_ops(2'd2, 2'd2, 2'd0, 2'd0, 2'd0); step(); chk("mul_2x2", uo_out, 8'h03);
    set_ops(2'd3, 2'd3, 2'd0, 2'd0, 2'd0); step(); chk("mul_3x3", uo_out, 8'h02);
    set_ops(2'd2, 2'd3, 2'd0, 2'd0, 2'd0); step(); chk("mul_2x3", uo_out, 8'h01);
    set_ops(2'd1, 2'd3, 2'd0, 2'd0, 2'd0); step(); chk("mul_1x3", uo_out, 8'h03);
    set_ops(2'd0, 2'd3, 2'd0, 2'd0, 2'd0); step(); chk("mul_0x3", uo_out, 8'h00);

    // Fully masked: a=2, b=3, a*b=1, mq=2 -> 3
    set_ops(2'd1, 2'd2, 2'd3, 2'd1, 2'd2); step(); chk("masked", uo_out, 8'h03);
    // Masks only on operands: a=1^2=3, b=2^2=0 -> 0, mq=1 -> 1
    set_ops(2'd1, 2'd2, 2'd2, 2'd2, 2'd1); step(); chk("masked_zero", uo_out, 8'h01);

    // Random sweep with ena / head / unused pins undriven
    ena = 1'bx;
    uio_in = {3'bxxx, 1'b0, 1'b0, 1'bx, 2'b00};
    for (int i = 0; i < 4; i++) begin hist_a[i] = 0; hist_b[i] = 0; end
    for (int n = 0; n < 999; n++) tick_rand("rand_qm");
    for (int i = 0; i < 4; i++) begin
      chk("hist_a", {7'd0, (hist_a[i] >= 180 && hist_a[i] <= 320)}, 8'd1);
      chk("hist_b", {7'd0, (hist_b[i] >= 180 && hist_b[i] <= 320)}, 8'd1);
    end
    ena = 1'b1;
    uio_in = 8'h00;

    // Reset clears chain before shifting
    reset = 1'b1; step(); reset = 1'b0;
    chk("pre_chain_tail", {7'd0, uo_out[2]}, 8'd0);

    // Shift 1,0,0,0,0,0,0,0: the leading 1 reaches the tail on the 8th pulse
    for (int p = 0; p < 8; p++) begin
      cfg_pulse(p == 0);
      chk("chain_tail", {7'd0, uo_out[2]}, {7'd0, CHAIN && (p == 7)});
    end
    for (int i = 0; i < 4; i++) tick_rand("chain_qm");

    // Set with a coincident prog_clk rise: set must win on the edge both land
    for (int i = 0; i < 8; i++) begin
      uio_in[4] = (i < 4);
      uio_in[3] = (i >= 1 && i < 5);
      tick_rand("set_qm");
      if (i >= 2) chk("set_tail", {7'd0, uo_out[2]}, {7'd0, CHAIN});
    end

    // Reset mid-stream discards the in-flight product
    set_ops(2'd2, 2'd2, 2'd0, 2'd0, 2'd0);
    reset = 1'b1;
    step();
    chk("midreset_qm", {6'd0, uo_out[1:0]}, 8'h00);
    chk("midreset_tail", {7'd0, uo_out[2]}, 8'h00);
    reset = 1'b0;
    set_ops(2'd3, 2'd3, 2'd0, 2'd0, 2'd1);
    step();
    chk("post_reset_qm", uo_out, 8'h03);
    for (int i = 0; i < 8; i++) tick_rand("post_reset_rand");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/tt_openfpga_top.md
Name: tt_openfpga_top

Overview:
- TinyTapeout top wrapping a fixed-function masked GF(2^2) multiplier ("maskmul") plus a configuration-chain shift register.
- Computes qm = (a ⊗ b) ⊕ mq, where a = am ⊕ ma and b = bm ⊕ mb.
- Operands stay share-split end to end: only masked shares and share cross-products are formed, never the plain operands.
- Pin-compatible with the standard TT user-project interface.

Parameters:
- CFG_LEN, 8, number of bits in the ccff configuration shift chain (≥1).

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  TT enable. Ignored: no logic depends on it, and X on it must not corrupt state.
- ui_in  in  8  operand shares: [1:0]=am, [3:2]=bm, [5:4]=ma, [7:6]=mb.
- uio_in  in  8  [1:0]=mq output mask, [2]=ccff_head, [3]=prog_clk, [4]=set, [7:5] unused.
- uo_out  out  8  [1:0]=qm masked product, [2]=ccff_tail, [7:3]=0.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all uio pins are inputs).

Behaviour:
- GF(2^2) element encoding and multiply:
  - Encoding: 0, 1, 2=x, 3=x+1; reduction polynomial x^2+x+1.
  - Multiply ⊗ for 2-bit p, r: c = p1&r1; q1 = (p1&r0)^(p0&r1)^c; q0 = (p0&r0)^c.
- Datapath: four combinational partial products ambm = am⊗bm, ammb = am⊗mb, bmma = bm⊗ma, mamb = ma⊗mb.
- Output register qm_r: qm_r <= (((ambm ^ mq) ^ ammb) ^ bmma) ^ mamb every clk edge.
  - Mask first, fixed XOR order.
  - No enable.
- Latency: exactly 1 cycle. Inputs present before edge N appear on uo_out[1:0] just after edge N.
- Throughput: one new operation per cycle, no handshake.
- prog_clk synchronizer: 2-flop synchronizer (ps0, ps1) on prog_clk; shift_pulse = ps0 & ~ps1.
- ccff_head synchronizer: passed through an identical 2-flop synchronizer so it stays aligned with shift_pulse.
- Config chain cfg[CFG_LEN-1:0]:
  - set_sync=1 (set via 2-flop sync): cfg <= all ones. Has priority over shift.
  - Else if shift_pulse: cfg <= {cfg[CFG_LEN-2:0], head_sync}.
  - Else: hold.
- ccff_tail = cfg[CFG_LEN-1], registered; no combinational path from inputs.
- Config chain does not affect the multiplier.
- prog_clk timing requirement: prog_clk high and low ≥3 clk cycles each; ccff_head stable ≥3 cycles before and after each prog_clk rise.
- Reset (synchronous, clk edge with reset=1):
  - qm_r, cfg, and all synchronizer flops <= 0.
  - Reset dominates set and shift.
  - Reset mid-operation discards the in-flight product; first valid qm is 1 cycle after reset deasserts.
- Unknown (X) on ccff_head or unused uio_in bits must not propagate to qm.

Optional Feature:
- Macro MASKMUL_CFG_CHAIN_EN.
- Defined: config chain and prog_clk/set synchronizers built as above; uo_out[2]=ccff_tail.
- Undefined: chain and synchronizers omitted; uo_out[2] tied 0; uio_in[4:2] ignored; multiplier behaviour unchanged.

Decomposition:
- Package maskmul_pkg: GF(2^2) element width constant (2), reduction-polynomial note, function gf4_mul(p,r), pin-index constants for ui_in/uio_in/uo_out fields.
- One sub-module gf4_mul_masked: four partial products + ordered XOR + output register.
- Top holds pin mapping, synchronizers and config chain.

Test Plan:
- Unmasked multiply: am=2, bm=2, ma=mb=mq=0 -> qm=3 after 1 edge; am=3, bm=3 -> qm=2; am=2, bm=3 -> qm=1.
- Fully masked: am=1, ma=3 (a=2); bm=2, mb=1 (b=3); mq=2 -> qm=3, i.e. qm⊕mq=1.
- Random sweep: 999 cycles of random 2-bit am, bm, ma, mb, mq with ena and ccff_head left X -> every cycle (qm⊕mq) = gf4_mul(am⊕ma, bm⊕mb). Plaintext value histograms near-uniform.
- Reset: assert reset mid-stream -> qm=0 and ccff_tail=0 on the next edge; correct products resume 1 cycle after release.
- Chain shift (CFG_LEN=8): shift pattern 1,0,0,0,0,0,0,0 via 8 prog_clk pulses (4 clk high / 4 low) -> ccff_tail=1 after the 8th synchronized rise; qm results unaffected throughout.
- Set: pulse set for 4 cycles -> ccff_tail=1 within 3 cycles and stays 1; a simultaneous prog_clk rise does not shift.
